// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM for the MIPS-lite core: sequences fetch/decode/execute/memory/writeback
// and drives the datapath control lines, stalling on a ready-handshaked memory with a wait-limit abort.
module mc_main_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic [1:0] pcsource,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;
    localparam logic [3:0] S_JMADR   = 4'd12;
    localparam logic [3:0] S_JMRD    = 4'd13;
    localparam logic [3:0] S_JMLINK  = 4'd14;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] FN_JMADD  = 6'b000001;

    logic [3:0]       r_state;
    logic [3:0]       w_nextState;
    logic [CNT_W-1:0] r_waitCnt;
    logic             w_memState;
    logic             w_abort;
    logic             w_illegal;

    assign w_memState = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR) || (r_state == S_JMRD);
    assign w_abort    = w_memState && !mem_ready && (r_waitCnt == CNT_W'(WAIT_LIMIT));
    assign w_illegal  = !((opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                          (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI));

    always_comb begin
        w_nextState = S_FETCH;
        case (r_state)
            S_FETCH:  w_nextState = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) w_nextState = S_MEMADR;
                else if (opcode == OP_RTYPE)                w_nextState = (funct == FN_JMADD) ? S_JMADR : S_EXEC;
                else if (opcode == OP_BEQ)                  w_nextState = S_BRANCH;
                else if (opcode == OP_J)                    w_nextState = S_JUMP;
                else if (opcode == OP_ADDI)                 w_nextState = S_ADDIEX;
                else                                        w_nextState = S_FETCH;
            end
            S_MEMADR: w_nextState = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_nextState = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_nextState = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_nextState = S_RWB;
            S_ADDIEX: w_nextState = S_ADDIWB;
            S_JMADR:  w_nextState = S_JMRD;
            S_JMRD:   w_nextState = mem_ready ? S_JMLINK : S_JMRD;
            default:  w_nextState = S_FETCH;
        endcase
        // A timed-out access abandons the instruction; nothing downstream gets written.
        if (w_abort) w_nextState = S_FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_waitCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (!w_memState || mem_ready || w_abort || (w_nextState != r_state))
                r_waitCnt <= '0;
            else
                r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    always_comb begin
        memread     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        pcsource    = 2'b00;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        regwrite    = 1'b0;
        regdst      = 2'b00;
        memtoreg    = 2'b00;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;
        state       = 4'd0;
        if (!reset) begin
            state   = r_state;
            mem_err = w_abort;
            case (r_state)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb    = 2'b11;
                    illegal_op = w_illegal;
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD, S_JMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 2'b01;
                end
                S_EXEC, S_JMADR: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_RWB: begin
                    regwrite = 1'b1;
                    regdst   = 2'b01;
                end
                S_ADDIWB: regwrite = 1'b1;
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    aluop       = 2'b01;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
                S_JMLINK: begin
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                    memtoreg = 2'b10;
                    pcwrite  = 1'b1;
                    pcsource = 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: directed scenarios plus random instruction/mem_ready traffic,
// checked against an instruction-path reference model.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       memread, memwrite, iord, irwrite, pcwrite, pcwritecond;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb, aluop;
    logic       regwrite;
    logic [1:0] regdst, memtoreg;
    logic       illegal_op, mem_err;
    logic [3:0] state;
    logic [17:0] dutCtrl;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: the state sequence an instruction walks, and where we are in it.
    int         path[$];
    int         pos;
    int         waitCnt;
    logic [5:0] curOp;
    logic [5:0] curFunct;
    bit         randomMode = 1'b0;

    mc_main_control #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .pcwritecond(pcwritecond), .pcsource(pcsource), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    assign dutCtrl = {memread, memwrite, iord, irwrite, pcwrite, pcwritecond, pcsource,
                      alusrca, alusrcb, aluop, regwrite, regdst, memtoreg};

    function automatic bit isMemState(int st);
        return (st == 0) || (st == 3) || (st == 5) || (st == 13);
    endfunction

    // Expected control word per state, packed in the same field order as dutCtrl.
    function automatic logic [17:0] expCtrl(int st, logic rdy);
        logic rd = 0, wr = 0, ad = 0, ir = 0, pw = 0, pwc = 0, sa = 0, rw = 0;
        logic [1:0] ps = 0, sb = 0, op = 0, rdst = 0, m2r = 0;
        case (st)
            0:       begin rd = 1; sb = 2'b01; ir = rdy; pw = rdy; end
            1:       sb = 2'b11;
            2, 10:   begin sa = 1; sb = 2'b10; end
            3, 13:   begin rd = 1; ad = 1; end
            5:       begin wr = 1; ad = 1; end
            4:       begin rw = 1; m2r = 2'b01; end
            6, 12:   begin sa = 1; op = 2'b10; end
            7:       begin rw = 1; rdst = 2'b01; end
            11:      rw = 1;
            8:       begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            9:       begin pw = 1; ps = 2'b10; end
            14:      begin rw = 1; rdst = 2'b10; m2r = 2'b10; pw = 1; ps = 2'b11; end
            default: ;
        endcase
        return {rd, wr, ad, ir, pw, pwc, ps, sa, sb, op, rw, rdst, m2r};
    endfunction

    task automatic buildPath(input logic [5:0] op, input logic [5:0] fn);
        path = '{0, 1};
        case (op)
            6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            6'b101011: begin path.push_back(2); path.push_back(5); end
            6'b000000: begin
                if (fn == 6'b000001) begin path.push_back(12); path.push_back(13); path.push_back(14); end
                else begin path.push_back(6); path.push_back(7); end
            end
            6'b000100: path.push_back(8);
            6'b000010: path.push_back(9);
            6'b001000: begin path.push_back(10); path.push_back(11); end
            default: ;
        endcase
    endtask

    task automatic newInstr();
        if (randomMode) begin
            case ($urandom_range(0, 7))
                0: curOp = 6'b100011;
                1: curOp = 6'b101011;
                2: curOp = 6'b000000;
                3: curOp = 6'b000100;
                4: curOp = 6'b000010;
                5: curOp = 6'b001000;
                6: curOp = 6'b111111;
                default: curOp = 6'b000000;
            endcase
            curFunct = ($urandom_range(0, 2) == 0) ? 6'b000001 : 6'($urandom_range(0, 63));
        end
        buildPath(curOp, curFunct);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        assert (got === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input logic rdy);
        int  st = path[pos];
        bit  illExp = (st == 1) && (path.size() == 2);
        bit  errExp = isMemState(st) && !rdy && (waitCnt == 15);
        check("state", 32'(state), 32'(st));
        check("ctrl", 32'(dutCtrl), 32'(expCtrl(st, rdy)));
        check("illegal_op", 32'(illegal_op), 32'(illExp));
        check("mem_err", 32'(mem_err), 32'(errExp));
    endtask

    task automatic modelStep(input logic rdy);
        int st = path[pos];
        if (isMemState(st) && !rdy) begin
            if (waitCnt == 15) begin
                pos = 0;
                waitCnt = 0;
                newInstr();
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
            pos++;
            if (pos == path.size()) begin
                pos = 0;
                newInstr();
            end
        end
    endtask

    task automatic applyStimulus(input logic rdy);
        @(negedge clk);
        reset = 1'b0;
        opcode = curOp;
        funct = curFunct;
        mem_ready = rdy;
        #2;
        checkOutput(rdy);
        @(posedge clk);
        modelStep(rdy);
    endtask

    // One reset cycle: every output must read zero, then the model restarts at FETCH.
    task automatic doReset(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        #2;
        check("reset_ctrl", 32'(dutCtrl), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        check("reset_pulses", 32'({illegal_op, mem_err}), 32'd0);
        @(posedge clk);
        curOp = op;
        curFunct = fn;
        pos = 0;
        waitCnt = 0;
        buildPath(op, fn);
    endtask

    initial begin
        reset = 1'b1;
        opcode = '0;
        funct = '0;
        mem_ready = 1'b0;
        curOp = '0;
        curFunct = '0;
        pos = 0;
        waitCnt = 0;

        // lw with memory always ready, then a second instruction start.
        doReset(6'b100011, 6'd0);
        repeat (6) applyStimulus(1'b1);

        // FETCH stalled three cycles before the instruction word arrives.
        doReset(6'b001000, 6'd0);
        repeat (3) applyStimulus(1'b0);
        repeat (5) applyStimulus(1'b1);

        // sw whose write never completes: abort after 16 MEMWR cycles.
        doReset(6'b101011, 6'd0);
        repeat (3) applyStimulus(1'b1);
        repeat (16) applyStimulus(1'b0);
        repeat (2) applyStimulus(1'b1);

        // lw read completing exactly on the limit cycle advances normally.
        doReset(6'b100011, 6'd0);
        repeat (3) applyStimulus(1'b1);
        repeat (15) applyStimulus(1'b0);
        repeat (3) applyStimulus(1'b1);

        // FETCH abort re-fetches.
        doReset(6'b000010, 6'd0);
        repeat (16) applyStimulus(1'b0);
        repeat (4) applyStimulus(1'b1);

        // jmadd, illegal opcode, beq, R-type, j.
        doReset(6'b000000, 6'b000001);
        repeat (6) applyStimulus(1'b1);
        doReset(6'b111111, 6'd0);
        repeat (3) applyStimulus(1'b1);
        doReset(6'b000100, 6'd0);
        repeat (4) applyStimulus(1'b1);
        doReset(6'b000000, 6'b100000);
        repeat (5) applyStimulus(1'b1);

        // Reset while in MEMRD, then resume at FETCH.
        doReset(6'b100011, 6'd0);
        repeat (3) applyStimulus(1'b1);
        doReset(6'b100011, 6'd0);
        repeat (2) applyStimulus(1'b1);

        // Random instructions with random memory stalls.
        randomMode = 1'b1;
        doReset(6'b001000, 6'd0);
        repeat (600) applyStimulus(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        // Long stalls to exercise the limit from random positions.
        repeat (200) applyStimulus(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
